// File: rtl/diff_out_app.sv
// diff_out_app: bus-mapped static level and pulse-burst driver for the 8 differential outputs
module diff_out_app (
    input  logic        xclk,
    input  logic        reset,
    input  logic        write_qualified,
    input  logic        read_qualified,
    input  logic [7:0]  ab,
    input  logic [15:0] db_in,
    output logic [15:0] db_out_DIFO,
    output logic        data_from_DIFO_avail,
    output logic [7:0]  diff_out
);
    localparam logic [7:0] WRITE_DIFF_OUT           = 8'h60;
    localparam logic [7:0] WRITE_DIFF_OUT_MASK      = 8'h61;
    localparam logic [7:0] WRITE_DIFF_OUT_HALF_PER  = 8'h62;
    localparam logic [7:0] WRITE_DIFF_OUT_PULSE_CNT = 8'h63;
    localparam logic [7:0] READ_DIFF_OUT            = 8'h64;
    localparam logic [7:0] READ_DIFF_OUT_STATUS     = 8'h65;
    localparam logic [7:0] READ_DIFF_OUT_REMAIN     = 8'h66;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  out_level_q, out_level_d, mask_q, mask_d, active_mask_q, active_mask_d;
    logic [15:0] half_per_q, half_per_d, hp_cnt_q, hp_cnt_d, remain_q, remain_d;
    logic        phase_q, phase_d, done_q, done_d;
    logic [7:0]  diff_out_q, diff_out_d;
    logic [15:0] db_out_q, db_out_d;
    logic        avail_q, avail_d;
    logic [15:0] hp_reload;
    logic        done_set;

    // Next-state: register writes, burst timing, abort/start, output and read mux
    always_comb begin
        state_d       = state_q;
        out_level_d   = out_level_q;
        mask_d        = mask_q;
        half_per_d    = half_per_q;
        active_mask_d = active_mask_q;
        phase_d       = phase_q;
        hp_cnt_d      = hp_cnt_q;
        remain_d      = remain_q;
        done_d        = done_q;
        db_out_d      = db_out_q;
        avail_d       = avail_q;
        done_set      = 1'b0;
        hp_reload     = (half_per_q == 16'd0) ? 16'd0 : half_per_q - 16'd1;
        if (write_qualified && ab == WRITE_DIFF_OUT) out_level_d = db_in[7:0];
        if (write_qualified && ab == WRITE_DIFF_OUT_MASK) mask_d = db_in[7:0];
        if (write_qualified && ab == WRITE_DIFF_OUT_HALF_PER) half_per_d = db_in;
        if (state_q == RUN) begin
            if (hp_cnt_q != 16'd0) begin
                hp_cnt_d = hp_cnt_q - 16'd1;
            end else begin
                hp_cnt_d = hp_reload;
                phase_d  = ~phase_q;
                if (phase_q) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d       = IDLE;
                        active_mask_d = 8'h00;
                        done_set      = 1'b1;
                    end
                end
            end
        end
        if (write_qualified && ab == WRITE_DIFF_OUT_PULSE_CNT) begin
            if (state_q == IDLE && db_in != 16'd0 && mask_q != 8'h00) begin
                state_d       = RUN;
                active_mask_d = mask_q;
                phase_d       = 1'b1;
                hp_cnt_d      = hp_reload;
                remain_d      = db_in;
                done_d        = 1'b0;
            end else if (state_q == RUN && db_in == 16'd0) begin
                state_d       = IDLE;
                phase_d       = 1'b0;
                active_mask_d = 8'h00;
                remain_d      = 16'd0;
                done_set      = 1'b0;
            end
        end
        done_d     = done_d | done_set;
        diff_out_d = out_level_d ^ (active_mask_d & {8{phase_d}});
        if (read_qualified) begin
            avail_d  = (ab == READ_DIFF_OUT) || (ab == READ_DIFF_OUT_STATUS) || (ab == READ_DIFF_OUT_REMAIN);
            db_out_d = (ab == READ_DIFF_OUT)        ? {8'h00, diff_out_d} :
                       (ab == READ_DIFF_OUT_STATUS) ? {14'h0, done_d, state_d == RUN} :
                       (ab == READ_DIFF_OUT_REMAIN) ? remain_d : 16'hFFFF;
            if (ab == READ_DIFF_OUT_STATUS && !done_set) done_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge xclk) begin
        if (reset) begin
            state_q       <= IDLE;
            out_level_q   <= 8'h00;
            mask_q        <= 8'h00;
            half_per_q    <= 16'd0;
            active_mask_q <= 8'h00;
            phase_q       <= 1'b0;
            hp_cnt_q      <= 16'd0;
            remain_q      <= 16'd0;
            done_q        <= 1'b0;
            diff_out_q    <= 8'h00;
            db_out_q      <= 16'd0;
            avail_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_level_q   <= out_level_d;
            mask_q        <= mask_d;
            half_per_q    <= half_per_d;
            active_mask_q <= active_mask_d;
            phase_q       <= phase_d;
            hp_cnt_q      <= hp_cnt_d;
            remain_q      <= remain_d;
            done_q        <= done_d;
            diff_out_q    <= diff_out_d;
            db_out_q      <= db_out_d;
            avail_q       <= avail_d;
        end
    end

    assign diff_out             = diff_out_q;
    assign db_out_DIFO          = db_out_q;
    assign data_from_DIFO_avail = avail_q;
endmodule

// File: tb/tb_diff_out_app.sv
// tb_diff_out_app: directed and random checks of diff_out_app against a timeline-based model
module tb_diff_out_app;
    localparam logic [7:0] AW_OUT  = 8'h60;
    localparam logic [7:0] AW_MASK = 8'h61;
    localparam logic [7:0] AW_HP   = 8'h62;
    localparam logic [7:0] AW_CNT  = 8'h63;
    localparam logic [7:0] AR_OUT  = 8'h64;
    localparam logic [7:0] AR_ST   = 8'h65;
    localparam logic [7:0] AR_REM  = 8'h66;

    logic        xclk = 1'b0;
    logic        reset = 1'b1;
    logic        write_qualified = 1'b0;
    logic        read_qualified = 1'b0;
    logic [7:0]  ab = 8'h00;
    logic [15:0] db_in = 16'h0000;
    logic [15:0] db_out_DIFO;
    logic        data_from_DIFO_avail;
    logic [7:0]  diff_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;

    diff_out_app dut (
        .xclk(xclk), .reset(reset), .write_qualified(write_qualified),
        .read_qualified(read_qualified), .ab(ab), .db_in(db_in),
        .db_out_DIFO(db_out_DIFO), .data_from_DIFO_avail(data_from_DIFO_avail),
        .diff_out(diff_out)
    );

    always #5 xclk = ~xclk;

    // Model: the burst is a timeline; m_end is the absolute edge at which the current half-period ends
    int          t = 0;
    int          m_end = 0;
    logic [7:0]  m_level = 0, m_mask = 0, m_amask = 0, m_out = 0;
    logic [15:0] m_hp = 0, m_remain = 0, m_rd = 0;
    logic        m_busy = 0, m_high = 0, m_done = 0, m_av = 0;

    function automatic int eff(input logic [15:0] h);
        return (h == 16'd0) ? 1 : int'(h);
    endfunction

    always @(posedge xclk) begin
        logic [15:0] old_hp;
        logic        busy_old, dset;
        t++;
        if (reset) begin
            m_level = 0; m_mask = 0; m_amask = 0; m_out = 0; m_hp = 0; m_remain = 0;
            m_rd = 0; m_busy = 0; m_high = 0; m_done = 0; m_av = 0;
        end else begin
            old_hp = m_hp;
            busy_old = m_busy;
            dset = 0;
            if (write_qualified && ab == AW_OUT) m_level = db_in[7:0];
            if (write_qualified && ab == AW_MASK) m_mask = db_in[7:0];
            if (write_qualified && ab == AW_HP) m_hp = db_in;
            if (m_busy && t == m_end) begin
                m_high = !m_high;
                m_end = t + eff(old_hp);
                if (!m_high) begin
                    m_remain = m_remain - 1;
                    if (m_remain == 0) begin
                        m_busy = 0; m_amask = 0; dset = 1;
                    end
                end
            end
            if (write_qualified && ab == AW_CNT) begin
                if (!busy_old && db_in != 0 && m_mask != 0) begin
                    m_busy = 1; m_amask = m_mask; m_high = 1; m_end = t + eff(old_hp);
                    m_remain = db_in; m_done = 0;
                end else if (busy_old && db_in == 0) begin
                    m_busy = 0; m_high = 0; m_amask = 0; m_remain = 0; dset = 0;
                end
            end
            m_done = m_done | dset;
            m_out = m_level ^ (m_high ? m_amask : 8'h00);
            if (read_qualified) begin
                m_av = 1;
                if (ab == AR_OUT) m_rd = {8'h00, m_out};
                else if (ab == AR_ST) begin
                    m_rd = {14'h0, m_done, m_busy};
                    if (!dset) m_done = 0;
                end else if (ab == AR_REM) m_rd = m_remain;
                else begin
                    m_rd = 16'hFFFF; m_av = 0;
                end
            end
        end
    end

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge xclk) begin
        if (chk_en) begin
            chk("model diff_out", {8'h00, diff_out}, {8'h00, m_out});
            chk("model db_out", db_out_DIFO, m_rd);
            chk("model avail", {15'h0, data_from_DIFO_avail}, {15'h0, m_av});
        end
    end

    task automatic cyc();
        @(posedge xclk);
        #1;
        write_qualified = 0;
        read_qualified = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        write_qualified = 1; ab = a; db_in = d;
        cyc();
    endtask

    task automatic rd(input logic [7:0] a);
        read_qualified = 1; ab = a;
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        idle(2);
        reset = 0;
        rd(AR_OUT);
        chk("reset readback", db_out_DIFO, 16'h0000);
        chk("reset readback avail", {15'h0, data_from_DIFO_avail}, 16'h0001);
        rd(8'hFF);
        chk("unmapped read", db_out_DIFO, 16'hFFFF);
        chk("unmapped avail", {15'h0, data_from_DIFO_avail}, 16'h0000);
        wr(AW_OUT, 16'h00A5);
        chk("level write", {8'h00, diff_out}, 16'h00A5);
        rd(AR_OUT);
        chk("level readback", db_out_DIFO, 16'h00A5);

        wr(AW_OUT, 16'h0000);
        wr(AW_MASK, 16'h0003);
        wr(AW_HP, 16'd3);
        wr(AW_CNT, 16'd2);
        chk("burst S", {8'h00, diff_out}, 16'h0003);
        idle(2);
        chk("burst S+2", {8'h00, diff_out}, 16'h0003);
        idle(1);
        chk("burst S+3", {8'h00, diff_out}, 16'h0000);
        idle(2);
        chk("burst S+5", {8'h00, diff_out}, 16'h0000);
        idle(1);
        chk("burst S+6", {8'h00, diff_out}, 16'h0003);
        idle(2);
        chk("burst S+8", {8'h00, diff_out}, 16'h0003);
        idle(1);
        chk("burst S+9", {8'h00, diff_out}, 16'h0000);
        rd(AR_ST);
        chk("status done", db_out_DIFO, 16'h0002);
        rd(AR_ST);
        chk("status cleared", db_out_DIFO, 16'h0000);

        wr(AW_HP, 16'd0);
        wr(AW_CNT, 16'd1);
        chk("h0 pulse high", {8'h00, diff_out}, 16'h0003);
        idle(1);
        chk("h0 pulse low", {8'h00, diff_out}, 16'h0000);
        wr(AW_MASK, 16'h0000);
        wr(AW_CNT, 16'd5);
        chk("mask0 no pulse", {8'h00, diff_out}, 16'h0000);
        rd(AR_ST);
        chk("mask0 not busy", db_out_DIFO & 16'h0001, 16'h0000);

        wr(AW_OUT, 16'h0050);
        wr(AW_MASK, 16'h000F);
        wr(AW_HP, 16'd10);
        wr(AW_CNT, 16'd100);
        chk("abort start", {8'h00, diff_out}, 16'h005F);
        idle(3);
        wr(AW_CNT, 16'd0);
        chk("abort level", {8'h00, diff_out}, 16'h0050);
        rd(AR_ST);
        chk("abort status", db_out_DIFO, 16'h0000);
        rd(AR_REM);
        chk("abort remain", db_out_DIFO, 16'h0000);

        wr(AW_CNT, 16'd100);
        idle(2);
        reset = 1;
        cyc();
        reset = 0;
        chk("reset mid-burst", {8'h00, diff_out}, 16'h0000);
        rd(AR_OUT);
        chk("reset out read", db_out_DIFO, 16'h0000);
        rd(AR_ST);
        chk("reset status read", db_out_DIFO, 16'h0000);
        rd(AR_REM);
        chk("reset remain read", db_out_DIFO, 16'h0000);

        for (int i = 0; i < 4000; i++) begin
            int op;
            op = $urandom_range(0, 99);
            if (op < 3) begin
                wr(AW_OUT, 16'($urandom));
            end else if (op < 6) begin
                wr(AW_MASK, ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 255)));
            end else if (op < 9) begin
                wr(AW_HP, 16'($urandom_range(0, 4)));
            end else if (op < 14) begin
                wr(AW_CNT, ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(1, 6)));
            end else if (op < 26) begin
                case ($urandom_range(0, 3))
                    0: rd(AR_OUT);
                    1: rd(AR_ST);
                    2: rd(AR_REM);
                    default: rd(8'($urandom));
                endcase
            end else if (op == 26 && $urandom_range(0, 9) == 0) begin
                reset = 1;
                cyc();
                reset = 0;
            end else begin
                idle(1);
            end
        end
        @(negedge xclk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
